// File: rtl/spi_cmd_deserializer.sv
// spi_cmd_deserializer: SPI mode-0 (MSB first) slave that collects WORD_WIDTH-bit
// command frames from asynchronous pins and presents each accepted word as
// cmd_data with a one-cycle cmd_valid strobe; malformed frames pulse frame_error.
// Optional feature macro: SPI_CMD_ECHO_EN -- when defined, the previously accepted
// word is shifted back out on miso during the next frame; otherwise miso is 0.
module spi_cmd_deserializer #(
  parameter int WORD_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic [WORD_WIDTH-1:0] cmd_data,
  output logic                  cmd_valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WORD_WIDTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

  state_t state, next_state;

  // Pin synchronisers: bit 0 is the first stage, MSB is the synced value.
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_hist, ss_hist;
  // Marks when the chain and history flop hold real pin samples rather than
  // reset values, so a select already low at reset release is not a falling edge.
  logic [SYNC_STAGES:0]   primed;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, ss_rise, ss_fall;

  logic [WORD_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  overrun;

  logic valid_nxt, err_nxt, busy_nxt;

  // Synchronise the SPI pins into the clock domain and keep one history flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b1;
      primed    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ss_hist   <= ss_sync[SYNC_STAGES-1];
      primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ss_rise   = ss_s & ~ss_hist;
  assign ss_fall   = ~ss_s & ss_hist & primed[SYNC_STAGES];

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic; a select rising edge always ends the frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ss_fall) next_state = ACTIVE;
      ACTIVE:  if (ss_rise) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM output decode: next values of the registered strobes and busy flag.
  always_comb begin
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    busy_nxt  = (next_state != IDLE);
    if (state == COMMIT) begin
      if (bit_cnt == FULL && !overrun) valid_nxt = 1'b1;
      else                             err_nxt   = 1'b1;
    end
  end

  // Register the outputs; cmd_data only changes on an accepted frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
      cmd_data    <= '0;
    end else begin
      cmd_valid   <= valid_nxt;
      frame_error <= err_nxt;
      busy        <= busy_nxt;
      if (valid_nxt) cmd_data <= shift_reg;
    end
  end

  // Shift in data bits and count them; a select rise in the same cycle as an
  // sclk rise takes priority, so that sclk edge is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      overrun   <= 1'b0;
    end else if (state == IDLE && ss_fall) begin
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else if (state == ACTIVE && !ss_rise && sclk_rise) begin
      shift_reg <= {shift_reg[WORD_WIDTH-2:0], mosi_s};
      if (bit_cnt == FULL) overrun <= 1'b1;
      else                 bit_cnt <= bit_cnt + CW'(1);
    end
  end

`ifdef SPI_CMD_ECHO_EN
  logic [WORD_WIDTH-1:0] tx_reg;
  logic                  sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_hist;

  // Load the last accepted word at frame start and shift it out MSB first,
  // advancing on sclk falling edges so the master samples on rising edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_reg <= '0;
    end else if (state == IDLE && ss_fall) begin
      tx_reg <= cmd_data;
    end else if (state == ACTIVE && sclk_fall) begin
      tx_reg <= {tx_reg[WORD_WIDTH-2:0], 1'b0};
    end
  end

  assign miso = tx_reg[WORD_WIDTH-1];
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_deserializer.sv
// Testbench for spi_cmd_deserializer: a table of directed frames, a reset
// corner-case sequence and randomized frames checked against a frame-level model.
module tb_spi_cmd_deserializer;
  localparam int W = 32;
  localparam int S = 2;

  logic clock = 1'b0, reset = 1'b1, sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic miso, cmd_valid, frame_error, busy;
  logic [W-1:0] cmd_data;

  always #5 clock = ~clock;

  spi_cmd_deserializer #(.WORD_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .frame_error(frame_error), .busy(busy)
  );

  int total = 0, passed = 0;
  int nval = 0, nerr = 0, nboth = 0, nmiso = 0;
  logic [W-1:0] vq[$];
  logic [W-1:0] echo_cap;
  int echo_n;
  logic [W-1:0] last_data;

  // Observe the strobes away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (cmd_valid) begin
        nval++;
        vq.push_back(cmd_data);
      end
      if (frame_error) nerr++;
      if (cmd_valid && frame_error) nboth++;
      if (miso) nmiso++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One SPI bit: data set up while sclk low, master samples miso just before rise.
  task automatic bitpulse(input logic b);
    mosi = b;
    cyc(4);
    if (echo_n < W) echo_cap = {echo_cap[W-2:0], miso};
    echo_n++;
    sclk = 1'b1;
    cyc(4);
    sclk = 1'b0;
  endtask

  // Full frame of n bits (MSB first from bits[n-1]); simul raises ss_n together
  // with the last sclk rise. Reports pulse latency and busy timing.
  task automatic frame(input logic [63:0] bits, input int n, input bit simul,
                       output int lat, output int blat,
                       output logic busy_pre, output logic busy_at);
    echo_n = 0; echo_cap = '0;
    lat = -1; blat = -1; busy_pre = 1'b0; busy_at = 1'b1;
    ss_n = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      if (busy && blat < 0) blat = k;
    end
    for (int i = 0; i < n; i++) begin
      if (simul && i == n - 1) begin
        mosi = bits[n-1-i];
        cyc(4);
        if (echo_n < W) echo_cap = {echo_cap[W-2:0], miso};
        echo_n++;
        sclk = 1'b1;
        ss_n = 1'b1;
      end else begin
        bitpulse(bits[n-1-i]);
      end
    end
    if (!simul) begin
      cyc(4);
      ss_n = 1'b1;
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      if (cmd_valid || frame_error) begin
        lat = k;
        busy_at = busy;
        break;
      end
      busy_pre = busy;
    end
    @(negedge clock); #1;
    sclk = 1'b0;
  endtask

  task automatic run_chk(input string tag, input logic [63:0] bits, input int n,
                         input bit simul, input bit ev, input logic [W-1:0] ed);
    int v0, e0, lat, blat;
    logic bp, ba;
    logic [W-1:0] prev, w;
    v0 = nval; e0 = nerr; prev = last_data;
    frame(bits, n, simul, lat, blat, bp, ba);
    chk({tag, " valid_pulses"}, 64'(nval - v0), 64'(ev));
    chk({tag, " error_pulses"}, 64'(nerr - e0), 64'(!ev));
    chk({tag, " cmd_data"}, 64'(cmd_data), 64'(ed));
    if (ev) begin
      w = (vq.size() > 0) ? vq.pop_front() : 'x;
      chk({tag, " strobed_word"}, 64'(w), 64'(ed));
    end
    chk({tag, " pulse_latency"}, 64'(lat), 64'(S + 2));
    chk({tag, " busy_rise"}, 64'(blat), 64'(S + 1));
    chk({tag, " busy_before_pulse"}, 64'(bp), 64'(1));
    chk({tag, " busy_at_pulse"}, 64'(ba), 64'(0));
`ifdef SPI_CMD_ECHO_EN
    if (n >= W) chk({tag, " echo"}, 64'(echo_cap), 64'(prev));
`endif
    last_data = ed;
  endtask

  typedef struct {
    logic [63:0]  bits;
    int           n;
    bit           simul;
    bit           exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int v0, e0;
    logic [W-1:0] word, mdata;
    logic [63:0] rb;
    int rn, eff;
    bit rs, ev;

    vecs[0] = '{64'hA5C30F81,    32, 1'b0, 1'b1, 32'hA5C30F81};
    vecs[1] = '{64'h12345678,    31, 1'b0, 1'b0, 32'hA5C30F81};
    vecs[2] = '{64'h1_23456789,  33, 1'b0, 1'b0, 32'hA5C30F81};
    vecs[3] = '{64'h0,            0, 1'b0, 1'b0, 32'hA5C30F81};
    vecs[4] = '{64'h00000001,    32, 1'b0, 1'b1, 32'h00000001};
    vecs[5] = '{64'hFFFFFFFE,    32, 1'b0, 1'b1, 32'hFFFFFFFE};
    vecs[6] = '{64'h78B52CD3,    33, 1'b1, 1'b1, 32'h3C5A9669};
    vecs[7] = '{64'hA5C30F81,    32, 1'b0, 1'b1, 32'hA5C30F81};
    vecs[8] = '{64'h00000000,    32, 1'b0, 1'b1, 32'h00000000};
    last_data = '0;

    // Reset state.
    cyc(2);
    chk("rst cmd_data", 64'(cmd_data), 64'(0));
    chk("rst cmd_valid", 64'(cmd_valid), 64'(0));
    chk("rst frame_error", 64'(frame_error), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst miso", 64'(miso), 64'(0));
    reset = 1'b0;
    cyc(6);

    // Directed frames, back to back with minimum select-high gap.
    for (int i = 0; i < 9; i++)
      run_chk($sformatf("vec%0d", i), vecs[i].bits, vecs[i].n, vecs[i].simul,
              vecs[i].exp_valid, vecs[i].exp_data);

    // Reset in the middle of a frame, released with select still low.
    ss_n = 1'b0;
    cyc(4);
    for (int i = 0; i < 16; i++) begin
      rb = 64'h12345678;
      bitpulse(rb[31-i]);
    end
    reset = 1'b1;
    cyc(1);
    chk("midrst cmd_data", 64'(cmd_data), 64'(0));
    chk("midrst cmd_valid", 64'(cmd_valid), 64'(0));
    chk("midrst frame_error", 64'(frame_error), 64'(0));
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst miso", 64'(miso), 64'(0));
    last_data = '0;
    v0 = nval; e0 = nerr;
    cyc(3);
    reset = 1'b0;
    cyc(4);
    for (int i = 0; i < 3; i++) bitpulse(1'b1);
    cyc(4);
    ss_n = 1'b1;
    cyc(10);
    chk("stale frame valid", 64'(nval - v0), 64'(0));
    chk("stale frame error", 64'(nerr - e0), 64'(0));
    run_chk("after_rst", 64'hDEADBEEF, 32, 1'b0, 1'b1, 32'hDEADBEEF);

    // Randomized frames against a frame-level model: a frame is accepted only
    // when exactly WORD_WIDTH sclk rises were counted before select rose.
    mdata = last_data;
    for (int r = 0; r < 16; r++) begin
      rb = {$urandom, $urandom};
      rs = 1'b0;
      case ($urandom_range(0, 5))
        0, 1, 2: rn = 32;
        3: begin rn = 33; rs = 1'b1; end
        4: rn = $urandom_range(0, 40);
        default: rn = 33;
      endcase
      eff = rs ? rn - 1 : rn;
      word = '0;
      for (int i = 0; i < rn && i < W; i++) word = {word[W-2:0], rb[rn-1-i]};
      ev = (eff == W);
      if (ev) mdata = word;
      run_chk($sformatf("rnd%0d_n%0d_s%0d", r, rn, rs), rb, rn, rs, ev, mdata);
    end

    chk("valid_and_error_together", 64'(nboth), 64'(0));
`ifndef SPI_CMD_ECHO_EN
    chk("miso_high_cycles", 64'(nmiso), 64'(0));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
